// File: rtl/key_strobe_pkg.sv
// Shared defaults and counter sizing for the key strobe generator.
package key_strobe_pkg;

    localparam int DIV_DEFAULT       = 4;
    localparam int DB_CYCLES_DEFAULT = 16;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus a persistence debouncer for a raw key input.
module key_debounce
    import key_strobe_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic key_level,
    output logic rise
);

    localparam int              CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

    logic          key_meta;
    logic          key_sync;
    logic [CW-1:0] db_cnt;
    logic          accept;

    // A new level is accepted on the edge where the counter has already seen
    // DB_CYCLES-1 differing clocks and the input still differs.
    assign accept = (key_sync != key_level) && (db_cnt == CNT_LAST);
    assign rise   = accept && key_sync;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta  <= 1'b0;
            key_sync  <= 1'b0;
            key_level <= 1'b0;
            db_cnt    <= '0;
        end else begin
            key_meta <= key;
            key_sync <= key_meta;
            if (key_sync == key_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                key_level <= key_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_strobe_gen.sv
// Debounced key press events held until consumed by a free-running strobe.
module key_strobe_gen
    import key_strobe_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic key,
    output logic enable,
    output logic a,
    output logic key_level,
    output logic overrun
);

    localparam int            SW       = cnt_width(DIV);
    localparam logic [SW-1:0] STB_LAST = SW'(DIV - 1);

    logic [SW-1:0] stb_cnt;
    logic          rise_now;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clock     (clock),
        .reset     (reset),
        .key       (key),
        .key_level (key_level),
        .rise      (rise_now)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stb_cnt <= '0;
            enable  <= 1'b0;
            a       <= 1'b0;
            overrun <= 1'b0;
        end else begin
            stb_cnt <= (stb_cnt == STB_LAST) ? '0 : stb_cnt + SW'(1);
            enable  <= (stb_cnt == STB_LAST);
            // A fresh press beats a simultaneous consume.
            if (rise_now) begin
                a <= 1'b1;
            end else if (enable) begin
                a <= 1'b0;
            end
            overrun <= rise_now && a && !enable;
        end
    end

endmodule

// File: tb/tb_key_strobe_gen.sv
// Directed bench for key_strobe_gen: a DIV=4 and a DIV=64 instance, both DB_CYCLES=4.
module tb_key_strobe_gen;

    logic clock;
    logic rst4, key4, en4, a4, lvl4, ov4;
    logic rst64, key64, en64, a64, lvl64, ov64;

    int ntests;
    int nfail;

    key_strobe_gen #(.DIV(4), .DB_CYCLES(4)) dut4 (
        .clock     (clock),
        .reset     (rst4),
        .key       (key4),
        .enable    (en4),
        .a         (a4),
        .key_level (lvl4),
        .overrun   (ov4)
    );

    key_strobe_gen #(.DIV(64), .DB_CYCLES(4)) dut64 (
        .clock     (clock),
        .reset     (rst64),
        .key       (key64),
        .enable    (en64),
        .a         (a64),
        .key_level (lvl64),
        .overrun   (ov64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        ntests++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int lvl_rise, lvl_step, a_rise, both, ovc, enc;
        logic pl, pa, found;

        ntests = 0;
        nfail  = 0;
        rst4   = 1'b1;
        key4   = 1'b0;
        rst64  = 1'b1;
        key64  = 1'b0;

        step();
        step();
        check("rst_enable", en4, 0);
        check("rst_a", a4, 0);
        check("rst_level", lvl4, 0);
        check("rst_overrun", ov4, 0);

        // Idle strobe: enable on edges 4, 8, 12 after release only.
        rst4 = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            step();
            check($sformatf("idle_en_e%0d", e), en4, (e % 4 == 0) ? 1 : 0);
            check($sformatf("idle_a_e%0d", e), a4, 0);
            check($sformatf("idle_lvl_e%0d", e), lvl4, 0);
            check($sformatf("idle_ov_e%0d", e), ov4, 0);
        end

        // Bounce 1,1,0,0 then steady 1 from step 5; level expected at step 10,
        // enable high at steps 3, 7, 11, 15, 19.
        lvl_rise = 0; lvl_step = 0; a_rise = 0; both = 0; ovc = 0;
        pl = lvl4; pa = a4;
        for (int i = 1; i <= 20; i++) begin
            key4 = (i <= 2) ? 1'b1 : (i <= 4) ? 1'b0 : 1'b1;
            step();
            if (lvl4 && !pl) begin
                lvl_rise++;
                lvl_step = i;
            end
            if (a4 && !pa) a_rise++;
            if (a4 && en4) both++;
            if (ov4) ovc++;
            if (i == 9)  check("press_a_before", a4, 0);
            if (i == 10) check("press_a_set", a4, 1);
            if (i == 11) begin
                check("press_en_consume", en4, 1);
                check("press_a_held", a4, 1);
            end
            if (i == 12) check("press_a_cleared", a4, 0);
            pl = lvl4;
            pa = a4;
        end
        check("bounce_level_rises", lvl_rise, 1);
        check("bounce_level_step", lvl_step, 10);
        check("bounce_a_rises", a_rise, 1);
        check("press_a_and_en", both, 1);
        check("press_overrun", ovc, 0);

        // Release: falling edge yields no event.
        key4 = 1'b0;
        a_rise = 0; ovc = 0; pa = a4;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a4 && !pa) a_rise++;
            if (ov4) ovc++;
            pa = a4;
        end
        check("release_level", lvl4, 0);
        check("release_no_event", a_rise, 0);
        check("release_overrun", ovc, 0);

        // DIV=64, key held high through reset; presses rise at 6, 26, 100, 129.
        key64 = 1'b1;
        step();
        step();
        check("rst64_level", lvl64, 0);
        rst64 = 1'b0;
        ovc = 0; both = 0; enc = 0;
        for (int e = 1; e <= 140; e++) begin
            if (e >= 11 && e <= 20)        key64 = 1'b0;
            else if (e >= 70 && e <= 94)   key64 = 1'b0;
            else if (e >= 105 && e <= 123) key64 = 1'b0;
            else                           key64 = 1'b1;
            step();
            if (ov64) ovc++;
            if (a64 && en64 && e <= 127) both++;
            if (en64 && e < 64) enc++;
            if (e == 5)   check("d64_a_before", a64, 0);
            if (e == 6) begin
                check("d64_held_key_event", a64, 1);
                check("d64_level", lvl64, 1);
            end
            if (e == 26) begin
                check("d64_overrun_pulse", ov64, 1);
                check("d64_merged_a", a64, 1);
            end
            if (e == 27)  check("d64_overrun_one_clk", ov64, 0);
            if (e == 64) begin
                check("d64_first_strobe", en64, 1);
                check("d64_a_until_strobe", a64, 1);
            end
            if (e == 65)  check("d64_a_consumed", a64, 0);
            if (e == 100) check("d64_third_press", a64, 1);
            if (e == 128) begin
                check("d64_strobe2", en64, 1);
                check("d64_a_pre_coincide", a64, 1);
            end
            if (e == 129) begin
                check("coincide_a", a64, 1);
                check("coincide_overrun", ov64, 0);
                check("coincide_en_low", en64, 0);
            end
            if (e == 130) check("coincide_a_held", a64, 1);
        end
        check("d64_overrun_count", ovc, 1);
        check("d64_consumed_count", both, 1);
        check("d64_no_early_enable", enc, 0);

        // Reset mid-debounce on dut4.
        key4 = 1'b1;
        step();
        step();
        step();
        #2 rst4 = 1'b1;
        #1;
        check("middb_rst_enable", en4, 0);
        check("middb_rst_a", a4, 0);
        check("middb_rst_level", lvl4, 0);
        check("middb_rst_overrun", ov4, 0);
        key4 = 1'b0;
        step();
        step();
        rst4 = 1'b0;
        a_rise = 0; pa = a4;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a4 && !pa) a_rise++;
            pa = a4;
        end
        check("middb_no_event", a_rise, 0);
        check("middb_level", lvl4, 0);

        // Reset while an event is pending.
        key4 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (a4) found = 1'b1;
        end
        check("pending_a_wait", found, 1);
        #2 rst4 = 1'b1;
        #1;
        check("pending_rst_a", a4, 0);
        check("pending_rst_level", lvl4, 0);
        check("pending_rst_enable", en4, 0);
        check("pending_rst_overrun", ov4, 0);
        key4 = 1'b0;
        step();
        rst4 = 1'b0;
        a_rise = 0; pa = a4;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a4 && !pa) a_rise++;
            pa = a4;
        end
        check("pending_no_event", a_rise, 0);
        check("pending_level", lvl4, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/key_strobe_gen.md
KEY_STROBE_GEN -- requirements
Module: key_strobe_gen

Interface
REQ-001 The block SHALL have parameter DIV, default 4, meaning strobe period in clocks (legal >= 2).
REQ-002 The block SHALL have parameter DB_CYCLES, default 16, meaning consecutive clocks of a changed input required to accept a new key level (legal >= 2).
REQ-003 The block SHALL have port clock, input, 1 bit, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit, the asynchronous active-high reset.
REQ-005 The block SHALL have port key, input, 1 bit, the raw asynchronous bouncing key.
REQ-006 The block SHALL have port enable, output, 1 bit, a one-clock strobe every DIV clocks, for the downstream FSM's enable.
REQ-007 The block SHALL have port a, output, 1 bit, a press event held until consumed by a strobe, for the downstream FSM's a input.
REQ-008 The block SHALL have port key_level, output, 1 bit, the debounced key level.
REQ-009 The block SHALL have port overrun, output, 1 bit, a one-clock pulse when a press is merged into an unconsumed event.

Function
REQ-010 The block SHALL pass key through a 2-flop synchronizer; key_sync is the second flop.
REQ-011 The debounce counter SHALL clear when key_sync == key_level and increment when they differ.
REQ-012 When the counter is at DB_CYCLES-1 and key_sync != key_level, key_level SHALL take key_sync and the counter SHALL clear on that edge.
REQ-013 Debounce counter width SHALL be $clog2(DB_CYCLES); it SHALL never exceed DB_CYCLES-1.
REQ-014 rise_now SHALL be the combinational condition that key_level goes 0->1 on the current edge; falling edges SHALL generate no event.
REQ-015 The strobe counter SHALL count 0..DIV-1 and wrap to 0; enable SHALL be registered, high for exactly the one clock after the counter reaches DIV-1.
REQ-016 With rise_now, a SHALL be set to 1; otherwise, if enable is 1, a SHALL clear to 0; otherwise a SHALL hold.
REQ-017 A set and a consume on the same edge SHALL leave a at 1, because the new event wins.
REQ-018 overrun SHALL be 1 for one clock when rise_now occurs while a == 1 and enable == 0; the events merge into one (a stays 1).
REQ-019 The strobe counter SHALL run independently of key activity; enable SHALL be gated by nothing.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from key to any output.

Reset
REQ-021 While reset is 1, all outputs SHALL be 0 (enable, a, key_level, overrun), and so SHALL the synchronizer flops and both counters.
REQ-022 Reset SHALL act asynchronously; asserting it mid-debounce or with a pending SHALL discard all state.
REQ-023 After reset release, the first enable high SHALL occur on the DIV-th rising edge.
REQ-024 A key held high through reset SHALL produce one press event once debounced after release.

Structure
REQ-025 Shared package key_strobe_pkg SHALL hold the default values of DIV and DB_CYCLES and a function for counter width.
REQ-026 The synchronizer and debounce logic SHALL be a sub-module key_debounce (ports clock, reset, key, key_level, rise); the strobe and event logic SHALL stay in the top.

Verification (DIV=4, DB_CYCLES=4 unless stated)
REQ-027 Release reset with key=0 -> enable high on edges 4, 8 and 12 only; a, key_level and overrun stay 0.
REQ-028 Bounce test: key 1,0,1 for 2 clocks each, then steady 1 -> key_level rises exactly once, 6 clocks after steady 1 starts (2 sync + 4 debounce); a pulses once.
REQ-029 Clean press -> a rises with key_level, stays 1 up to and including the first enable-high clock, and clears the next edge; exactly one clock has a=1 and enable=1.
REQ-030 DIV=64: two clean presses 20 clocks apart -> one overrun pulse; a stays 1 until the next strobe; only one event is consumed.
REQ-031 Assert reset 2 clocks into debounce, and again with a=1 -> all outputs 0 immediately; no event after release while key=0.
REQ-032 Rise coincident with enable-high while a=1 -> a stays 1 and overrun stays 0.
